// File: rtl/serial_addsub_8b.sv
// serial_addsub_8b: bit-serial two's-complement add/sub, LSB first, start/done handshake; optional saturation via SERIAL_ADDSUB_SAT_EN
module serial_addsub_8b #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, sum, sum_n, res_n;
  logic [CNT_W-1:0] count;
  logic carry, s, maj, last, ovf_n;
  assign busy = state == RUN;
  assign done = state == DONE;
  // single full-adder slice on the operand LSBs; on the last bit sa[0]/sb[0] are the operand MSBs
  always_comb begin
    s = sa[0] ^ sb[0] ^ carry;
    maj = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    last = count == CNT_W'(WIDTH - 1);
    sum_n = {s, sum[WIDTH-1:1]};
    ovf_n = carry ^ maj;
`ifdef SERIAL_ADDSUB_SAT_EN
    res_n = ovf_n ? {sa[0], {(WIDTH-1){~sa[0]}}} : sum_n;
`else
    res_n = sum_n;
`endif
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: IDLE -> RUN on start, RUN -> DONE after the last bit, DONE -> IDLE always
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? RUN :
              (state == RUN && last)   ? DONE :
              (state == DONE)          ? IDLE : state;
  end
  // operand latch, bit-serial shifting and single-update capture of result/flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      sum <= '0;
      carry <= 1'b0;
      count <= '0;
      result <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= sub ? ~b : b;
      carry <= sub;
      count <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sum <= sum_n;
      carry <= maj;
      count <= count + CNT_W'(1);
      if (last) begin
        result <= res_n;
        cout <= maj;
        ovf <= ovf_n;
        zero <= res_n == '0;
      end
    end
endmodule

// File: tb/tb_serial_addsub_8b.sv
// tb_serial_addsub_8b: randomized and directed checks of serial_addsub_8b against an arithmetic reference model
module tb_serial_addsub_8b;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0, result;
  logic busy, done, cout, ovf, zero;
  int n_vec = 0, n_err = 0;
  logic [7:0] obs_r;
  logic obs_c, obs_o, obs_z, obs_done_after;
  int obs_bcyc;
  bit obs_to;

  serial_addsub_8b dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // expected {cout, ovf, zero, result} from plain integer arithmetic
  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic ms);
    logic [7:0] be, r;
    logic [8:0] s9;
    int t;
    logic o;
    be = ms ? ~mb : mb;
    s9 = {1'b0, ma} + {1'b0, be} + {8'd0, ms};
    t = ms ? int'($signed(ma)) - int'($signed(mb)) : int'($signed(ma)) + int'($signed(mb));
    o = (t > 127) || (t < -128);
    r = s9[7:0];
`ifdef SERIAL_ADDSUB_SAT_EN
    if (o) r = (t > 127) ? 8'h7F : 8'h80;
`endif
    return {s9[8], o, r == 8'h00, r};
  endfunction

  // drive one operation from IDLE, capture outputs at the done pulse, then step to the next cycle
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic is);
    start = 1'b1; a = ia; b = ib; sub = is;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    obs_bcyc = 0;
    obs_to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        obs_to = 1'b0;
        break;
      end
      if (busy) obs_bcyc++;
      @(negedge clk);
    end
    obs_r = result; obs_c = cout; obs_o = ovf; obs_z = zero;
    @(negedge clk);
    obs_done_after = done;
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({busy, done, result, cout, ovf, zero} !== 13'd0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b result=%h cout=%b ovf=%b zero=%b, need all 0", busy, done, result, cout, ovf, zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [16:0] tbl [5] = '{{8'd25, 8'd17, 1'b0}, {8'd100, 8'd50, 1'b0}, {8'd5, 8'd5, 1'b1},
                             {8'd3, 8'd5, 1'b1}, {8'h80, 8'd1, 1'b1}};
    logic [10:0] e;
    for (int i = 0; i < 5; i++) begin
      e = model(tbl[i][16:9], tbl[i][8:1], tbl[i][0]);
      do_op(tbl[i][16:9], tbl[i][8:1], tbl[i][0]);
      n_vec++;
      if (obs_to || obs_bcyc != 8 || obs_done_after !== 1'b0) begin
        n_err++;
        $display("FAIL directed[%0d] timing: timeout=%0d busy_cycles=%0d done_next=%b, need 0/8/0", i, obs_to, obs_bcyc, obs_done_after);
      end
      n_vec++;
      if ({obs_c, obs_o, obs_z, obs_r} !== e) begin
        n_err++;
        $display("FAIL directed[%0d] value: got c=%b o=%b z=%b r=%h, need c=%b o=%b z=%b r=%h",
                 i, obs_c, obs_o, obs_z, obs_r, e[10], e[9], e[8], e[7:0]);
      end
      n_vec++;
      if (result !== e[7:0]) begin
        n_err++;
        $display("FAIL directed[%0d] hold: result=%h after DONE, need %h", i, result, e[7:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] ra, rb;
    logic rs;
    logic [10:0] e;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'h80; rs = 1'b1; end
      if (i == 1) begin ra = 8'h7F; rb = 8'h01; rs = 1'b0; end
      if (i == 2) begin ra = 8'hFF; rb = 8'h01; rs = 1'b0; end
      e = model(ra, rb, rs);
      do_op(ra, rb, rs);
      n_vec++;
      if (obs_to || obs_bcyc != 8 || {obs_c, obs_o, obs_z, obs_r} !== e) begin
        n_err++;
        $display("FAIL random[%0d] %h %s %h: got c=%b o=%b z=%b r=%h bc=%0d to=%0d, need c=%b o=%b z=%b r=%h",
                 i, ra, rs ? "-" : "+", rb, obs_c, obs_o, obs_z, obs_r, obs_bcyc, obs_to, e[10], e[9], e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] e;
    int gap;
    e = model(8'd60, 8'd70, 1'b0);
    do_op(8'd60, 8'd70, 1'b0);
    start = 1'b1; a = 8'd9; b = 8'd4; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || result !== e[7:0]) begin
      n_err++;
      $display("FAIL back_to_back accept: busy=%b result=%h, need busy=1 result=%h", busy, result, e[7:0]);
    end
    e = model(8'd9, 8'd4, 1'b1);
    gap = 0;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    n_vec++;
    if (gap != 8 || result !== e[7:0] || zero !== e[8]) begin
      n_err++;
      $display("FAIL back_to_back second: cycles=%0d result=%h zero=%b, need 8 %h %b", gap, result, zero, e[7:0], e[8]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int dones, busys;
    start = 1'b1; a = 8'd10; b = 8'd20; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hEE; sub = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h55; b = 8'hAA;
    dones = 0; busys = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        n_vec++;
        if (result !== 8'd30 || cout !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL ignore_start value: result=%0d cout=%b ovf=%b busy=%b, need 30 0 0 0", result, cout, ovf, busy);
        end
      end
      if (dones > 0 && busy) busys++;
      @(negedge clk);
    end
    n_vec++;
    if (dones != 1 || busys != 0) begin
      n_err++;
      $display("FAIL ignore_start count: dones=%0d busy_after=%0d, need 1 and 0", dones, busys);
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    logic [10:0] e;
    start = 1'b1; a = 8'd200; b = 8'd100; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: busy=%b done=%b result=%h cout=%b, need 0 0 00 0", busy, done, result, cout);
    end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done || busy) dones++;
    end
    n_vec++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_abort stale: %0d cycles with busy/done after abort, need 0", dones);
    end
    e = model(8'd1, 8'd1, 1'b0);
    do_op(8'd1, 8'd1, 1'b0);
    n_vec++;
    if (obs_to || obs_bcyc != 8 || obs_r !== e[7:0] || obs_z !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort restart: result=%h zero=%b bc=%0d to=%0d, need %h 0 8 0", obs_r, obs_z, obs_bcyc, obs_to, e[7:0]);
    end
  endtask

  // watch for the exclusive busy/done property throughout the run
  always @(negedge clk)
    if (rst_n && busy && done) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_done_excl: busy=%b done=%b, need never both 1", busy, done);
    end

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_ignore_start;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_addsub_8b.md
Name: serial_addsub_8b

Overview:
- Bit-serial two's-complement adder/subtractor that consumes the inverter stage's output: B is inverted (not_1b per bit) with carry-in 1 for subtract.
- Processes one bit per clock, LSB first, behind a start/done handshake.
- Produces a registered result plus carry, signed-overflow and zero flags for the datapath/ALU stage downstream.
- Trades area for latency: one full-adder slice, shift registers and a small FSM.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, bit counter width (derived; not overridden).

Ports:
- clk      input   1      rising-edge clock
- rst_n    input   1      asynchronous active-low reset
- start    input   1      request; sampled only in IDLE
- sub      input   1      0 = A+B, 1 = A-B; latched with start
- a        input   WIDTH  operand A; latched with start
- b        input   WIDTH  operand B; latched with start
- busy     output  1      high while in RUN
- done     output  1      one-cycle pulse; result/flags valid
- result   output  WIDTH  registered sum/difference
- cout     output  1      carry out of MSB (subtract: 1 = no borrow)
- ovf      output  1      signed overflow
- zero     output  1      result == 0

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, result=0, cout=0, ovf=0, zero=0; internal shift registers, carry and counter cleared. Reset mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on an edge with start=1:
  - latch sa=a;
  - latch sb=b when sub=0, or sb=~b (bitwise inversion) when sub=1;
  - carry=sub; count=0.
- RUN, each edge:
  - s = sa[0]^sb[0]^carry; carry <= majority(sa[0],sb[0],carry);
  - sa and sb shift right; s enters the MSB of the internal sum register; count++.
  - On the edge where count==WIDTH-1, capture the carry into the MSB (c_msb) as well as the final carry.
  - After exactly WIDTH RUN edges -> DONE.
- Entering DONE, registered in a single update:
  - result <= sum; cout <= final carry; ovf <= c_msb ^ final carry; zero <= (result value == 0).
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
- Latency: start edge E0; result/flags/done visible after edge E(WIDTH); WIDTH+2 cycles per op including return to IDLE.
- start while in RUN or DONE: ignored, not queued. Back-to-back start is accepted in the first IDLE cycle after DONE.
- a, b, sub may change freely after the start edge without effect.
- result and flags hold their last values until the next DONE; no intermediate values are visible on result.
- busy=1 only in RUN; done and busy are never both 1.

Optional Feature:
- Macro SERIAL_ADDSUB_SAT_EN.
- Defined: on ovf=1, result saturates:
  - to the signed maximum (0x7F for WIDTH=8) when the MSBs of A and the effective B were both 0;
  - to the signed minimum (0x80) when both were 1.
  - ovf still reads 1; zero is computed on the saturated value; cout is unchanged (raw carry).
- Undefined: result wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan:
- Reset released, start a=25, b=17, sub=0 -> busy 8 cycles; done pulse; result=42, cout=0, ovf=0, zero=0.
- a=100, b=50, sub=0 -> result=150 (0x96), cout=0, ovf=1. With SERIAL_ADDSUB_SAT_EN: result=0x7F, ovf=1.
- a=5, b=5, sub=1 -> result=0, zero=1, cout=1, ovf=0. Then a=3, b=5, sub=1 -> result=0xFE, cout=0, ovf=0, zero=0.
- a=0x80, b=1, sub=1 -> result=0x7F, ovf=1, cout=1. With SERIAL_ADDSUB_SAT_EN: result=0x80.
- Start 10+20; pulse start again with a=0xFF at count=3; change a/b mid-RUN -> single done, result=30, no second op begins.
- Start 200+100; drop rst_n at count=4 -> immediately busy=0, result=0, no done. Release rst_n and start 1+1 -> result=2 after 8 cycles.
